ntt_stream_host: RTL and testbench
==================================

Name: ntt_stream_host

Overview:
- Host-side counterpart to the NTT core's serial coefficient port.
- Accepts one polynomial frame from upstream over valid/ready and buffers it.
- Replays the frame to the core as an unbroken burst of `valid` beats, which the core needs because it has no backpressure.
- Captures the core's serial result stream once `is_done` rises, then returns it downstream over valid/ready with a frame-last marker.

Parameters:
- DATA_W, 16: coefficient width; matches DATA_SIZE_ARB.
- RING_SIZE, 1024: coefficients per frame; power of two, at least 4.
- ADDR_W, $clog2(RING_SIZE): local, derived; buffer address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream coefficient valid.
- in_data  in  DATA_W  upstream coefficient, natural order.
- in_ready  out  1  high only in LOAD.
- core_valid  out  1  drives the core's `valid`.
- core_data  out  DATA_W  drives the core's `data_i`.
- core_done  in  1  the core's `is_done`.
- core_result  in  DATA_W  the core's `data_o`.
- out_valid  out  1  downstream result valid.
- out_data  out  DATA_W  downstream result coefficient.
- out_last  out  1  marks the final coefficient of the frame.
- out_ready  in  1  downstream accept.
- busy  out  1  high in every state except LOAD with count 0.

Behaviour:
- Reset (reset low, async): state=LOAD, counters=0, in_ready=1, core_valid=0, core_data=0, out_valid=0, out_data=0, out_last=0, busy=0. Buffer RAM contents are not cleared. Reset mid-frame discards the frame; there is no partial output.
- Storage: two RING_SIZE x DATA_W single-port-write, registered-read RAMs, in_buf and res_buf.
- LOAD:
  - Each in_valid&&in_ready beat writes in_buf[wcnt]; wcnt increments.
  - On beat RING_SIZE-1: go to SEND and clear the count. in_ready drops the next cycle.
- SEND:
  - Reads in_buf sequentially.
  - core_valid is high for exactly RING_SIZE consecutive cycles with no gaps.
  - First core_valid is 1 cycle after entering SEND (RAM read latency).
  - core_data = in_buf[k] on the k-th valid beat.
  - core_done is ignored in SEND.
  - After the last beat: core_valid=0, go to WAIT.
- WAIT:
  - Level-sensitive on core_done.
  - In the first cycle core_done==1, write core_result into res_buf[0] and go to CAPTURE with count=1.
- CAPTURE:
  - Each cycle writes core_result into res_buf[count], regardless of core_done.
  - Count-driven: exactly RING_SIZE samples total. A core_done drop mid-stream is ignored.
  - After sample RING_SIZE-1, go to DRAIN.
- DRAIN:
  - First out_valid is exactly 2 cycles after the last capture write.
  - out_data/out_last are held stable while out_valid&&!out_ready.
  - Each accepted beat advances the index. Prefetch keeps zero bubbles under continuous out_ready.
  - out_last=1 only with index RING_SIZE-1.
  - On accepting the last beat: out_valid=0, go to LOAD with wcnt=0.
- Wrap-around: all counters are ADDR_W+1 bits wide and compared against RING_SIZE-1. Indices never wrap inside a state.
- in_valid outside LOAD is ignored and not acknowledged.
- Simultaneous last-drain-accept and in_valid: the in_valid is not taken that cycle, because in_ready is still 0.

Optional Feature:
- Macro: NTT_STREAM_HOST_TIMEOUT_EN.
- With the macro defined:
  - Adds parameter TIMEOUT (default 65535) and output `timeout_err` (1 bit, reset 0).
  - In WAIT, a cycle counter increments each cycle.
  - If it reaches TIMEOUT without core_done, set timeout_err sticky and return to LOAD with wcnt=0. No output is produced.
  - timeout_err clears only on reset.
- Without the macro: no counter and no port; WAIT holds indefinitely.

Test Plan:
All scenarios use RING_SIZE=8 and DATA_W=16.
1. Load 0..7 with in_valid held high -> in_ready low after 8 beats; core_valid high for exactly 8 consecutive cycles carrying 0,1,...,7; busy=1.
2. Model core asserts core_done 20 cycles after the burst, driving 100..107 -> out_data 100..107 in order, out_last only on 107, first out_valid 2 cycles after capture of 107.
3. out_ready toggled 1,0,0,1,... during DRAIN -> out_data is stable during stalls; no beat is lost or duplicated; the sequence is still 100..107.
4. Assert reset low for 1 cycle mid-SEND after beat 3 -> core_valid=0 immediately; state=LOAD, in_ready=1; the next full frame 20..27 is sent cleanly.
5. core_done pulses high for 1 cycle only -> still 8 samples captured; downstream receives 8 beats.
6. With NTT_STREAM_HOST_TIMEOUT_EN and TIMEOUT=50, core_done never asserted -> timeout_err=1 at cycle 50 of WAIT; in_ready=1 the following cycle; out_valid stays 0.

Source files
------------

// File: rtl/ntt_stream_host.sv
// Host-side buffer for the NTT core's serial port: load a frame, burst it to the core, capture and drain the result.
// Optional WAIT-state watchdog enabled by defining NTT_STREAM_HOST_TIMEOUT_EN (adds TIMEOUT and timeout_err).
module ntt_stream_host #(
  parameter int DATA_W    = 16,
  parameter int RING_SIZE = 1024
`ifdef NTT_STREAM_HOST_TIMEOUT_EN
  , parameter int TIMEOUT = 65535
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              core_valid,
  output logic [DATA_W-1:0] core_data,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
`ifdef NTT_STREAM_HOST_TIMEOUT_EN
  , output logic            timeout_err
`endif
);

  localparam int ADDR_W = $clog2(RING_SIZE);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(RING_SIZE - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  localparam logic [2:0] ST_LOAD    = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  logic [DATA_W-1:0] in_buf  [RING_SIZE];
  logic [DATA_W-1:0] res_buf [RING_SIZE];
  logic [2:0]        state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] addr;
  logic              res_wr;

  assign addr     = cnt[ADDR_W-1:0];
  assign in_ready = (state == ST_LOAD);
  assign busy     = (state != ST_LOAD) || (cnt != '0);
  assign res_wr   = (state == ST_CAPTURE) || ((state == ST_WAIT) && core_done);

  // Buffer writes carry no reset so both arrays map onto plain RAM.
  always_ff @(posedge clk) begin
    if ((state == ST_LOAD) && in_valid)
      in_buf[addr] <= in_data;
    if (res_wr)
      res_buf[addr] <= core_result;
  end

`ifdef NTT_STREAM_HOST_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        wait_expired;
  assign wait_expired = (state == ST_WAIT) && !core_done && (wait_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 32'd1 : 32'd0;
      if (wait_expired)
        timeout_err <= 1'b1;
    end
  end
`else
  logic wait_expired;
  assign wait_expired = 1'b0;
`endif

  // core_data and out_data double as the registered read ports of in_buf and res_buf.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      core_valid <= 1'b0;
      core_data  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      core_valid <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              state <= ST_SEND;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        ST_SEND: begin
          core_valid <= 1'b1;
          core_data  <= in_buf[addr];
          if (cnt == LAST) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        ST_WAIT: begin
          if (core_done) begin
            state <= ST_CAPTURE;
            cnt   <= ONE;
          end else if (wait_expired) begin
            state <= ST_LOAD;
            cnt   <= '0;
          end
        end
        ST_CAPTURE: begin
          if (cnt == LAST) begin
            state <= ST_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        ST_DRAIN: begin
          // Refill the output register whenever it is empty or being accepted; hold it on a stall.
          if (out_valid && out_last && out_ready) begin
            state     <= ST_LOAD;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (!(out_valid && out_last) && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_data  <= res_buf[addr];
            out_last  <= (cnt == LAST);
            if (cnt != LAST)
              cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= ST_LOAD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_stream_host.sv
// Scoreboard bench for ntt_stream_host with RING_SIZE=8: core-side and downstream expectations are queued as stimulus is driven.
// Define NTT_STREAM_HOST_TIMEOUT_EN to also exercise the WAIT watchdog with TIMEOUT=50.
module tb_ntt_stream_host;

  localparam int DATA_W    = 16;
  localparam int RING_SIZE = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              core_valid;
  logic [DATA_W-1:0] core_data;
  logic              core_done = 1'b0;
  logic [DATA_W-1:0] core_result = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic              busy;
`ifdef NTT_STREAM_HOST_TIMEOUT_EN
  logic              timeout_err;
`endif

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_core [$];
  logic [DATA_W-1:0] exp_out  [$];

  ntt_stream_host #(
    .DATA_W(DATA_W),
    .RING_SIZE(RING_SIZE)
`ifdef NTT_STREAM_HOST_TIMEOUT_EN
    , .TIMEOUT(50)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .core_valid(core_valid),
    .core_data(core_data),
    .core_done(core_done),
    .core_result(core_result),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .busy(busy)
`ifdef NTT_STREAM_HOST_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one frame upstream with in_valid held high; in_valid stays high afterwards to probe that it is ignored.
  task automatic applyStimulus(input int base);
    in_valid = 1'b1;
    for (int i = 0; i < RING_SIZE; i++) begin
      in_data = DATA_W'(base + i);
      exp_core.push_back(DATA_W'(base + i));
      checkOutput("load_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_data = 16'hDEAD;
    checkOutput("ready_drop", 32'(in_ready), 32'd0);
    checkOutput("busy_send", 32'(busy), 32'd1);
  endtask

  task automatic run_burst();
    int lat;
    int len;
    lat = 0;
    len = 0;
    while (!core_valid && lat < 10) begin
      tick();
      lat++;
    end
    checkOutput("send_lat", 32'(lat), 32'd1);
    while (core_valid && len < 2 * RING_SIZE) begin
      if (exp_core.size() > 0)
        checkOutput("core_data", 32'(core_data), 32'(exp_core.pop_front()));
      else
        checkOutput("core_extra_beat", 32'(len), 32'(RING_SIZE));
      len++;
      tick();
    end
    checkOutput("burst_len", 32'(len), 32'(RING_SIZE));
    checkOutput("ignored_in_wait", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic core_reply(input int base, input bit pulse, input int delay);
    int lat;
    repeat (delay) tick();
    for (int i = 0; i < RING_SIZE; i++) begin
      core_done   = pulse ? (i == 0) : 1'b1;
      core_result = DATA_W'(base + i);
      exp_out.push_back(DATA_W'(base + i));
      tick();
    end
    core_done   = 1'b0;
    core_result = '0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    checkOutput("drain_lat", 32'(lat), 32'd2);
  endtask

  task automatic drain(input bit [3:0] pattern, input bit all_ready);
    int cyc;
    int bubbles;
    cyc = 0;
    bubbles = 0;
    while (exp_out.size() > 0 && cyc < 100) begin
      out_ready = pattern[cyc % 4];
      if (out_valid) begin
        checkOutput("out_data", 32'(out_data), 32'(exp_out[0]));
        checkOutput("out_last", 32'(out_last), 32'(exp_out.size() == 1));
        if (out_ready)
          void'(exp_out.pop_front());
      end else begin
        bubbles++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput("drain_done", 32'(exp_out.size()), 32'd0);
    if (all_ready)
      checkOutput("bubbles", 32'(bubbles), 32'd0);
    checkOutput("out_valid_end", 32'(out_valid), 32'd0);
    checkOutput("in_ready_end", 32'(in_ready), 32'd1);
    checkOutput("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_core_valid", 32'(core_valid), 32'd0);
    checkOutput("rst_core_data", 32'(core_data), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
`ifdef NTT_STREAM_HOST_TIMEOUT_EN
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif
    tick();
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] frame 0..7, continuous drain");
    applyStimulus(0);
    run_burst();
    core_reply(100, 1'b0, 20);
    drain(4'b1111, 1'b1);

    $display("[TB] frame 50..57, stalled drain");
    applyStimulus(50);
    run_burst();
    core_reply(100, 1'b0, 6);
    drain(4'b1001, 1'b0);

    $display("[TB] reset mid-SEND");
    applyStimulus(10);
    in_valid = 1'b0;
    n = 0;
    while (!core_valid && n < 10) begin
      tick();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput("pre_reset_data", 32'(core_data), 32'(exp_core.pop_front()));
      tick();
    end
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_core_valid", 32'(core_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    exp_core.delete();
    tick();
    reset = 1'b1;
    tick();
    applyStimulus(20);
    run_burst();
    core_reply(200, 1'b0, 4);
    drain(4'b1111, 1'b1);

    $display("[TB] single-cycle core_done pulse");
    applyStimulus(30);
    run_burst();
    core_reply(300, 1'b1, 5);
    drain(4'b1111, 1'b1);

`ifdef NTT_STREAM_HOST_TIMEOUT_EN
    $display("[TB] WAIT timeout");
    applyStimulus(40);
    run_burst();
    n = 1;
    while (!timeout_err && n < 200) begin
      checkOutput("timeout_no_out", 32'(out_valid), 32'd0);
      tick();
      n++;
    end
    checkOutput("timeout_cycle", 32'(n), 32'd50);
    tick();
    checkOutput("timeout_in_ready", 32'(in_ready), 32'd1);
    checkOutput("timeout_out_valid", 32'(out_valid), 32'd0);
    repeat (5) tick();
    checkOutput("timeout_sticky", 32'(timeout_err), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
